// File: rtl/wave_capture_pkg.sv
// Shared capture/display constants: FSM encodings, buffer geometry and the
// sample-to-RAM conversion used by both the capture and display sides.
package wave_capture_pkg;

    // Samples per buffer half; the RAM offset field is 8 bits wide.
    localparam int NUM_SAMPLES_DEFAULT = 256;
    localparam int OFFSET_W            = 8;
    localparam int ADDR_W              = OFFSET_W + 1;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } capture_state_e;

    // Signed top byte to offset-binary: flipping the MSB adds 128 mod 256.
    function automatic logic [7:0] to_offset_binary(input logic [7:0] top_byte);
        return top_byte ^ 8'h80;
    endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Flags a negative-to-nonnegative crossing between the previous and the
// current sample, qualified by the sample strobe.
module zero_cross_detect (
    input  logic prev_msb_i,
    input  logic curr_msb_i,
    input  logic strobe_i,
    output logic trigger_o
);

    // Previous sample negative, current sample zero or positive.
    assign trigger_o = strobe_i & prev_msb_i & ~curr_msb_i;

endmodule

// File: rtl/wave_capture.sv
// Triggered waveform capture into a double-buffered sample RAM. Waits for a
// rising zero crossing, writes NUM_SAMPLES samples into the half the display
// is not reading, then swaps halves once the display is idle.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic [ADDR_W-1:0]   write_address,
    output logic                write_enable,
    output logic [7:0]          write_sample,
    output logic                read_index
);

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(NUM_SAMPLES - 1);

    capture_state_e       state_q, state_d;
    logic [OFFSET_W-1:0]  offset_q, offset_d;
    logic [SAMPLE_W-1:0]  prev_sample_q, prev_sample_d;
    logic                 read_index_q, read_index_d;
    logic                 write_enable_q, write_enable_d;
    logic [ADDR_W-1:0]    write_address_q, write_address_d;
    logic [7:0]           write_sample_q, write_sample_d;

    logic                 trigger;
    logic [7:0]           sample_byte;

    // Only the MSB of the stored sample and the top byte of the incoming one
    // are consumed; the remaining bits are deliberately left unused.
    logic                 unused_low_bits;
    assign unused_low_bits = ^{prev_sample_q[SAMPLE_W-2:0], new_sample_in[SAMPLE_W-9:0]};

    assign sample_byte = new_sample_in[SAMPLE_W-1 -: 8];

    zero_cross_detect u_zero_cross_detect (
        .prev_msb_i (prev_sample_q[SAMPLE_W-1]),
        .curr_msb_i (new_sample_in[SAMPLE_W-1]),
        .strobe_i   (new_sample_ready),
        .trigger_o  (trigger)
    );

    // Previous sample tracks every strobe regardless of capture state.
    always_comb begin
        prev_sample_d = new_sample_ready ? new_sample_in : prev_sample_q;
    end

    // Capture FSM next-state and registered write-port values.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a variable unassigned (which would infer a latch).
        state_d         = state_q;
        offset_d        = offset_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;

        case (state_q)
            ARMED: begin
                if (trigger) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, {OFFSET_W{1'b0}}};
                    write_sample_d  = to_offset_binary(sample_byte);
                    offset_d        = OFFSET_W'(1);
                    state_d         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, offset_q};
                    write_sample_d  = to_offset_binary(sample_byte);
                    if (offset_q == LAST_OFFSET) begin
                        offset_d = '0;
                        state_d  = WAIT;
                    end else begin
                        offset_d = offset_q + OFFSET_W'(1);
                    end
                end
            end
            WAIT: begin
                // Swap halves only while the display is off the waveform, so
                // the half it reads never changes mid-scan.
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    // State and output registers; reset abandons any partial capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ARMED;
            offset_q        <= '0;
            prev_sample_q   <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational blocks.
            state_q         <= state_d;
            offset_q        <= offset_d;
            prev_sample_q   <= prev_sample_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: expected RAM writes are queued when the
// stimulus is driven and compared when the write strobe appears.
module tb_wave_capture;
    import wave_capture_pkg::*;

    logic               clk;
    logic               reset;
    logic               new_sample_ready;
    logic signed [15:0] new_sample_in;
    logic               wave_display_idle;
    logic [8:0]         write_address;
    logic               write_enable;
    logic [7:0]         write_sample;
    logic               read_index;

    int n_asserts;
    int n_fails;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    wave_capture #(
        .SAMPLE_W    (16),
        .NUM_SAMPLES (256)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; a queued expectation must appear right after this edge.
    task automatic step(input logic rdy, input logic [15:0] smp, input logic idle,
                        input logic exp_wr, input logic [8:0] exp_addr);
        wr_t w;
        new_sample_ready  = rdy;
        new_sample_in     = smp;
        wave_display_idle = idle;
        if (exp_wr) begin
            w.addr = exp_addr;
            w.data = {~smp[15], smp[14:8]};
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        check("write_enable", 32'(write_enable), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            if (write_enable) begin
                check("write_address", 32'(write_address), 32'(w.addr));
                check("write_sample", 32'(write_sample), 32'(w.data));
            end
        end
    endtask

    task automatic check_state(input string tag, input capture_state_e exp_state,
                               input logic exp_ri);
        check({tag, "_state"}, 32'(dut.state_q), 32'(exp_state));
        check({tag, "_read_index"}, 32'(read_index), 32'(exp_ri));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"}, 32'(write_enable), 32'd0);
        check({tag, "_addr"}, 32'(write_address), 32'd0);
        check({tag, "_data"}, 32'(write_sample), 32'd0);
        check({tag, "_ri"}, 32'(read_index), 32'd0);
    endtask

    initial begin
        n_asserts         = 0;
        n_fails           = 0;
        reset             = 1'b0;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check_state("reset", ARMED, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Positive samples only: no crossing, no writes.
        step(1'b1, 16'sd100, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd50,  1'b0, 1'b0, 9'h0);
        step(1'b0, 16'sd0,   1'b0, 1'b0, 9'h0);
        check_state("no_cross", ARMED, 1'b0);

        // -256 then +256: trigger writes offset 0 of half 1 with 0x81.
        step(1'b1, -16'sd256, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd256,  1'b0, 1'b1, 9'h100);
        check_state("triggered", ACTIVE, 1'b0);

        // 255 strobes spaced 3 cycles fill 0x101..0x1FF, then WAIT.
        for (int i = 1; i < 256; i++) begin
            step(1'b1, 16'(i * 389 - 30000), 1'b0, 1'b1, {1'b1, 8'(i)});
            step(1'b0, 16'sd0, 1'b0, 1'b0, 9'h0);
            step(1'b0, 16'sd0, 1'b0, 1'b0, 9'h0);
        end
        check_state("full_half1", WAIT, 1'b0);
        step(1'b1, 16'sd1234, 1'b0, 1'b0, 9'h0);
        check_state("wait_ignores", WAIT, 1'b0);

        // Display busy for 20 cycles, then idle swaps halves.
        for (int i = 0; i < 20; i++) step(1'b0, 16'sd0, 1'b0, 1'b0, 9'h0);
        check_state("wait_busy", WAIT, 1'b0);
        step(1'b0, 16'sd0, 1'b1, 1'b0, 9'h0);
        check_state("swap1", ARMED, 1'b1);

        // Capture into half 0, back-to-back strobes.
        step(1'b1, -16'sd10, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd10,  1'b0, 1'b1, 9'h000);
        for (int i = 1; i < 256; i++) begin
            step(1'b1, 16'(i * 257 - 32768), 1'b0, 1'b1, {1'b0, 8'(i)});
        end
        check_state("full_half0", WAIT, 1'b1);

        // Idle and a crossing in the same cycle: swap only, no trigger.
        step(1'b1, -16'sd1, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd0,  1'b1, 1'b0, 9'h0);
        check_state("swap_no_trig", ARMED, 1'b0);
        step(1'b0, 16'sd0, 1'b0, 1'b0, 9'h0);
        step(1'b1, -16'sd5, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd5,  1'b0, 1'b1, 9'h100);
        for (int i = 1; i < 256; i++) begin
            step(1'b1, 16'(i * 131 + 7), 1'b0, 1'b1, {1'b1, 8'(i)});
        end
        check_state("full_half1b", WAIT, 1'b0);
        step(1'b0, 16'sd0, 1'b1, 1'b0, 9'h0);
        check_state("swap2", ARMED, 1'b1);

        // 100 writes into half 0, then asynchronous reset mid-capture.
        step(1'b1, -16'sd3, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd3,  1'b0, 1'b1, 9'h000);
        for (int i = 1; i < 100; i++) begin
            step(1'b1, 16'(i * 613 - 20000), 1'b0, 1'b1, {1'b0, 8'(i)});
        end
        check_state("mid_capture", ACTIVE, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        check_state("async_reset", ARMED, 1'b0);
        check("async_reset_offset", 32'(dut.offset_q), 32'd0);
        check("async_reset_prev", 32'(dut.prev_sample_q), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Capture restarts in half 1.
        step(1'b1, -16'sd7, 1'b0, 1'b0, 9'h0);
        step(1'b1, 16'sd7,  1'b0, 1'b1, 9'h100);
        check_state("restart", ACTIVE, 1'b0);
        step(1'b1, 16'sd700, 1'b0, 1'b1, 9'h101);
        step(1'b0, 16'sd0,   1'b0, 1'b0, 9'h0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, width of signed input audio sample.
REQ-002 SHALL have parameter NUM_SAMPLES, default 256, samples captured per buffer half.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port new_sample_ready  input  1  one-cycle strobe, new_sample_in valid.
REQ-006 SHALL have port new_sample_in  input  SAMPLE_W  signed two's-complement audio sample.
REQ-007 SHALL have port wave_display_idle  input  1  high while display is not scanning the waveform region.
REQ-008 SHALL have port write_address  output  9  sample RAM write address {write_index, offset[7:0]}.
REQ-009 SHALL have port write_enable  output  1  sample RAM write strobe.
REQ-010 SHALL have port write_sample  output  8  unsigned sample written to RAM.
REQ-011 SHALL have port read_index  output  1  buffer half the display reads; write half is ~read_index.

Function
REQ-012 SHALL implement FSM with states ARMED, ACTIVE, WAIT.
REQ-013 SHALL keep prev_sample register, updated with new_sample_in on every new_sample_ready in all states.
REQ-014 SHALL detect trigger when new_sample_ready=1, prev_sample MSB=1 and new_sample_in MSB=0 (negative-to-nonnegative crossing).
REQ-015 ARMED: on trigger SHALL write triggering sample at offset 0, set offset counter to 1, go to ACTIVE; otherwise SHALL write nothing.
REQ-016 ACTIVE: on each new_sample_ready SHALL write sample at current offset and increment offset; write at offset NUM_SAMPLES-1 SHALL transition to WAIT, counter wraps to 0.
REQ-017 ACTIVE: cycles without new_sample_ready SHALL hold offset and produce no write.
REQ-018 WAIT: SHALL ignore samples for writing; on wave_display_idle=1 SHALL toggle read_index and go to ARMED on same edge.
REQ-019 WAIT with wave_display_idle=1 and new_sample_ready=1 simultaneously SHALL toggle read_index, enter ARMED, update prev_sample, and NOT evaluate a trigger on that sample.
REQ-020 Write outputs SHALL be registered: write_enable pulses 1 cycle, exactly one cycle after accepting strobe, with write_address and write_sample valid that same cycle.
REQ-021 write_sample SHALL equal new_sample_in[SAMPLE_W-1 -: 8] with MSB inverted (offset-binary, i.e. +128 mod 256).
REQ-022 write_address[8] SHALL equal ~read_index at the accepting edge; read_index SHALL never change during ARMED or ACTIVE.
REQ-023 write_enable SHALL be 0 in every cycle not following an accepted write.

Reset
REQ-024 While reset=0: state=ARMED, offset=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0, asynchronously.
REQ-025 Reset mid-capture SHALL abandon the partial buffer; after release capture SHALL restart in ARMED with write half 1.

Structure
REQ-026 State encodings and NUM_SAMPLES default SHALL live in the shared project constants package/header used by wave_display.
REQ-027 Trigger detection SHALL be a sub-module zero_cross_detect (inputs prev/current MSB and strobe, output trigger); no other sub-modules.

Verification
REQ-028 Reset release, samples +100,+50 (no crossing) -> write_enable stays 0, state ARMED, read_index=0.
REQ-029 Samples -256 then +256 (16-bit) -> one cycle later write_enable=1, write_address=9'h100, write_sample=8'h81.
REQ-030 After trigger, 255 further strobes spaced 3 cycles -> addresses 9'h101..9'h1FF in order, then FSM WAIT; 256th extra strobe produces no write.
REQ-031 In WAIT, wave_display_idle=0 for 20 cycles then 1 -> read_index toggles to 1 on idle edge; next capture writes at 9'h000..9'h0FF.
REQ-032 Reset asserted after 100 ACTIVE writes -> outputs 0 immediately; next trigger writes address 9'h100 with read_index=0.
REQ-033 WAIT with idle=1 and strobe carrying crossing (-1 -> 0) same cycle -> read_index toggles, ARMED, no write; following -5,+5 triggers normally.
